spi_cmd_receiver: RTL
=====================

# spi_cmd_receiver

SPI mode-0 responder for the FPGA graphics design. It receives fixed-width command words from the MCU, which acts as initiator, over sck/sdi/cs_n. It presents each complete word to the drawing/frame-buffer logic through a valid/ready handshake, and shifts the previously received word back out on sdo for loopback checking. All logic runs on the 25.175 MHz VGA pixel clock; the SPI pins are asynchronous and are synchronized internally.

## Interface
- WORD_BITS, 32, command word width in bits (≥ 8); MSB first on the wire
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer (≥ 2)
- clk  input  1  VGA pixel clock (25.175 MHz); sole clock
- reset  input  1  synchronous, active-low reset; block is reset when reset == 0 at a clk rising edge
- sck  input  1  SPI clock from MCU, asynchronous, idles low
- sdi  input  1  SPI data from MCU, asynchronous
- cs_n  input  1  SPI chip select, active-low, asynchronous
- sdo  output  1  SPI data to MCU
- cmd_data  output  WORD_BITS  last accepted command word
- cmd_valid  output  1  cmd_data holds an unconsumed word
- cmd_ready  input  1  consumer accepts cmd_data when cmd_valid && cmd_ready
- overrun  output  1  sticky; a completed word was dropped because cmd_valid was held

## Operation
- sck, sdi and cs_n each pass through a SYNC_STAGES-deep synchronizer. An extra flop on synced sck produces one-cycle sck_rise/sck_fall pulses.
- State machine:
  - IDLE: synced cs_n == 1. bit_cnt = 0, shift register is don't-care, sdo = 0.
  - IDLE -> ACTIVE when synced cs_n == 0. On entry, the sdo shifter loads echo_reg and sdo = echo_reg[WORD_BITS-1].
  - ACTIVE -> IDLE when synced cs_n == 1. A partial word is discarded. No valid and no overrun result.
- In ACTIVE on sck_rise:
  - shift_reg <= {shift_reg[WORD_BITS-2:0], sdi_sync}.
  - bit_cnt increments.
  - When bit_cnt == WORD_BITS-1 the word completes: bit_cnt wraps to 0, and back-to-back words within one cs_n low period are supported.
- In ACTIVE on sck_fall: the sdo shifter shifts left and sdo presents the next bit.
- At a word boundary (bit_cnt == 0 after a completion), the sdo shifter reloads from echo_reg, which has already been updated to the word just completed.
- On word completion:
  - echo_reg <= completed word.
  - If !cmd_valid || cmd_ready: cmd_data <= word and cmd_valid <= 1.
  - Otherwise the word is dropped: overrun <= 1 and cmd_data is unchanged.
- Handshake:
  - When cmd_valid && cmd_ready with no completion in the same cycle, cmd_valid <= 0 next cycle.
  - When completion and acceptance occur in the same cycle, the new word loads and cmd_valid stays 1.
  - cmd_data is stable while cmd_valid && !cmd_ready.
- overrun is cleared only by reset.
- Reset values (all outputs and state): sdo = 0, cmd_valid = 0, cmd_data = 0, overrun = 0, echo_reg = 0, bit_cnt = 0, state = IDLE, synchronizer flops = sck 0, cs_n 1.
- Reset mid-word discards all progress. The first word after reset begins at the next cs_n low period.

## Timing
- sck high and low times must each be ≥ SYNC_STAGES+2 clk periods. That gives sck ≤ 3.1 MHz at defaults.
- cs_n falling edge to first sck rise must be ≥ SYNC_STAGES+2 clk periods.
- The last sck fall before cs_n rises must be ≥ SYNC_STAGES+2 clk periods before cs_n rises.
- sdi must be stable from SYNC_STAGES+1 clk before an sck rising edge until SYNC_STAGES+1 clk after it. Mode 0 with sdi changing on falling edges meets this.
- Latency from the final sck rising edge at the pin to cmd_valid high is SYNC_STAGES+2 clk cycles, which is 4 at defaults.
- sdo changes SYNC_STAGES+2 clk cycles after an sck falling edge or after cs_n falls. The MCU samples on the next sck rise.
- cmd_valid falls 1 cycle after the accepting edge.

## Test plan
- Reset, then send 0xA5C30F12 with cmd_ready = 1 -> cmd_valid pulses one cycle, 4 clk after the last sck rise, with cmd_data = 0xA5C30F12. sdo carries 0x00000000 and overrun = 0.
- Send 0x12345678 immediately after, in the same cs_n low period -> cmd_data = 0x12345678. sdo returned 0xA5C30F12 during that word.
- Hold cmd_ready = 0 and send 0x11111111 then 0x22222222 -> cmd_data stays 0x11111111 and cmd_valid stays 1. overrun = 1 after the second word. Raising cmd_ready clears cmd_valid next cycle; overrun stays 1.
- Raise cs_n after 13 bits, then send full word 0xDEADBEEF -> no cmd_valid for the fragment. Exactly one valid follows, with 0xDEADBEEF.
- Assert reset (0) after 20 bits of a word with cmd_valid = 1 -> next cycle all outputs are 0. A following full word 0x0F0F0F0F is received correctly and sdo returns 0.
- With cmd_valid = 1, hold cmd_ready = 1 in the exact cycle a new word 0xCAFEF00D completes -> cmd_valid stays 1, cmd_data = 0xCAFEF00D, overrun stays 0.

Source files
------------

// File: rtl/spi_cmd_receiver.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_receiver
// Description : SPI mode-0 responder; receives MSB-first command words on a
//               single pixel clock and echoes the previous word back on sdo.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cmd_receiver #(
    parameter int WORD_BITS   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sck,
    input  logic                 sdi,
    input  logic                 cs_n,
    output logic                 sdo,
    output logic [WORD_BITS-1:0] cmd_data,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic                 overrun
);
    localparam int                CNT_W    = $clog2(WORD_BITS);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_BITS - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic [SYNC_STAGES-1:0] csn_sync_q;
    logic                   sck_prev_q;
    logic                   sck_rise_q;
    logic                   sck_fall_q;
    logic                   sdi_q;
    logic                   csn_q;

    state_t                 state_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [WORD_BITS-1:0]   shift_q;
    logic [WORD_BITS-1:0]   tx_q;
    logic [WORD_BITS-1:0]   echo_q;
    logic [WORD_BITS-1:0]   cmd_data_q;
    logic                   cmd_valid_q;
    logic                   overrun_q;
    logic                   sdo_q;

    logic [WORD_BITS-1:0]   word_d;
    logic                   word_done;

    // sdi and cs_n get the same extra stage as the edge pulses so all three stay aligned
    always_ff @(posedge clk) begin
        if (!reset) begin
            sck_sync_q <= '0;
            sdi_sync_q <= '0;
            csn_sync_q <= '1;
            sck_prev_q <= 1'b0;
            sck_rise_q <= 1'b0;
            sck_fall_q <= 1'b0;
            sdi_q      <= 1'b0;
            csn_q      <= 1'b1;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
            csn_sync_q <= {csn_sync_q[SYNC_STAGES-2:0], cs_n};
            sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
            sck_rise_q <= sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
            sck_fall_q <= ~sck_sync_q[SYNC_STAGES-1] & sck_prev_q;
            sdi_q      <= sdi_sync_q[SYNC_STAGES-1];
            csn_q      <= csn_sync_q[SYNC_STAGES-1];
        end
    end

    assign word_d    = {shift_q[WORD_BITS-2:0], sdi_q};
    assign word_done = (state_q == ST_ACTIVE) && !csn_q && sck_rise_q && (bit_cnt_q == LAST_BIT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            sdo_q       <= 1'b0;
            echo_q      <= '0;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    bit_cnt_q <= '0;
                    sdo_q     <= 1'b0;
                    if (!csn_q) begin
                        state_q <= ST_ACTIVE;
                        tx_q    <= echo_q;
                        sdo_q   <= echo_q[WORD_BITS-1];
                    end
                end
                ST_ACTIVE: begin
                    if (csn_q) begin
                        state_q   <= ST_IDLE;
                        bit_cnt_q <= '0;
                        sdo_q     <= 1'b0;
                    end else if (sck_rise_q) begin
                        shift_q   <= word_d;
                        bit_cnt_q <= (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + CNT_W'(1);
                    end else if (sck_fall_q) begin
                        // A zero count on a falling edge marks a word boundary: start the new echo
                        if (bit_cnt_q == '0) begin
                            tx_q  <= echo_q;
                            sdo_q <= echo_q[WORD_BITS-1];
                        end else begin
                            tx_q  <= {tx_q[WORD_BITS-2:0], 1'b0};
                            sdo_q <= tx_q[WORD_BITS-2];
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (word_done) begin
                echo_q <= word_d;
                if (!cmd_valid_q || cmd_ready) begin
                    cmd_data_q  <= word_d;
                    cmd_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (cmd_valid_q && cmd_ready) begin
                cmd_valid_q <= 1'b0;
            end
        end
    end

    assign sdo       = sdo_q;
    assign cmd_data  = cmd_data_q;
    assign cmd_valid = cmd_valid_q;
    assign overrun   = overrun_q;

endmodule
`default_nettype wire
